// File: rtl/lr35902_dma.sv
// ---------------------------------------------------------------------------
// lr35902_dma
//
// OAM DMA engine for the video chip. A CPU write to FF46 latches a source
// page and, after a short start delay, copies BYTES bytes from XX00.. into
// OAM 00.. at one byte per M-cycle (four gbclk phases). Reads are issued
// towards the external bus or local VRAM (selection is done at top level);
// writes go to the OAM port.
//
// Ports:
//   clk        gbclk, all state on rising edge
//   reset      asynchronous, active-high
//   reg_din    CPU write data (source page)
//   reg_write  one-cycle strobe, FF46 selected and written
//   reg_dout   last written source page
//   adr_rd     source address ({src_hi, idx} while transferring, else 0000)
//   rd         source read strobe (phases 0..2)
//   data_in    source read data (already muxed VRAM/ext)
//   adr_wr     OAM byte index (valid with wr, else 00)
//   wr         OAM write strobe (phase 3)
//   data_out   byte being written to OAM
//   active     DMA owns OAM; CPU OAM access blocked
//   drv_ext    DMA drives the external adr/n_read pins
// ---------------------------------------------------------------------------
module lr35902_dma #(
  parameter int unsigned BYTES        = 160,
  parameter int unsigned CLK_PER_BYTE = 4,
  parameter int unsigned START_DELAY  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  reg_din,
  input  logic        reg_write,
  output logic [7:0]  reg_dout,
  output logic [15:0] adr_rd,
  output logic        rd,
  input  logic [7:0]  data_in,
  output logic [7:0]  adr_wr,
  output logic        wr,
  output logic [7:0]  data_out,
  output logic        active,
  output logic        drv_ext
);

  localparam int unsigned DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

  localparam logic [DW-1:0] DLY_LAST  = DW'(START_DELAY - 1);
  localparam logic [7:0]    IDX_LAST  = 8'(BYTES - 1);
  localparam logic [1:0]    PH_WRITE  = 2'(CLK_PER_BYTE - 1);
  localparam logic [1:0]    PH_SAMPLE = 2'(CLK_PER_BYTE - 2);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    XFER
  } state_t;

  state_t         state, state_nx;
  logic [7:0]     page, page_nx;
  logic [DW-1:0]  dly, dly_nx;
  logic [7:0]     idx, idx_nx;
  logic [1:0]     phase, phase_nx;
  logic           hold, hold_nx;
  logic [7:0]     data_q, data_nx;

  logic [7:0]     src_hi;
  logic           in_xfer;

  // Pages E0..FF are the echo of C0..DF.
  always_comb begin
    src_hi = page;
    if (page >= 8'hE0) begin
      src_hi = page - 8'h20;
    end
  end

  assign in_xfer = (state == XFER);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      page   <= '0;
      dly    <= '0;
      idx    <= '0;
      phase  <= '0;
      hold   <= 1'b0;
      data_q <= '0;
    end else begin
      state  <= state_nx;
      page   <= page_nx;
      dly    <= dly_nx;
      idx    <= idx_nx;
      phase  <= phase_nx;
      hold   <= hold_nx;
      data_q <= data_nx;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    page_nx  = page;
    dly_nx   = dly;
    idx_nx   = idx;
    phase_nx = phase;
    hold_nx  = hold;
    data_nx  = data_q;

    unique case (state)
      IDLE: begin
        if (reg_write) begin
          state_nx = DELAY;
          page_nx  = reg_din;
          dly_nx   = '0;
          hold_nx  = 1'b0;
        end
      end

      DELAY: begin
        if (reg_write) begin
          // Restart while already delaying: keep OAM owned.
          page_nx = reg_din;
          dly_nx  = '0;
          hold_nx = 1'b1;
        end else if (dly == DLY_LAST) begin
          state_nx = XFER;
          idx_nx   = '0;
          phase_nx = '0;
        end else begin
          dly_nx = dly + DW'(1);
        end
      end

      XFER: begin
        if (reg_write) begin
          // Abort the byte in flight (its wr is masked combinationally)
          // and restart with OAM still owned.
          state_nx = DELAY;
          page_nx  = reg_din;
          dly_nx   = '0;
          hold_nx  = 1'b1;
        end else begin
          if (phase == PH_SAMPLE) begin
            data_nx = data_in;
          end
          if (phase == PH_WRITE) begin
            phase_nx = '0;
            if (idx == IDX_LAST) begin
              state_nx = IDLE;
              hold_nx  = 1'b0;
            end else begin
              idx_nx = idx + 8'd1;
            end
          end else begin
            phase_nx = phase + 2'd1;
          end
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs (decoded from registered state so reset clears them at once)
  // -------------------------------------------------------------------------
  always_comb begin
    reg_dout = page;
    data_out = data_q;
    adr_rd   = '0;
    rd       = 1'b0;
    wr       = 1'b0;
    adr_wr   = '0;
    active   = 1'b0;
    drv_ext  = 1'b0;

    if (in_xfer) begin
      adr_rd  = {src_hi, idx};
      rd      = (phase != PH_WRITE);
      // A register write in the write phase restarts the engine; the
      // pending OAM write must not land.
      wr      = (phase == PH_WRITE) && !reg_write;
      active  = 1'b1;
      drv_ext = (src_hi[7:5] != 3'b100);
    end else if (state == DELAY) begin
      active = hold;
    end

    if (wr) begin
      adr_wr = idx;
    end
  end

endmodule

// File: tb/tb_lr35902_dma.sv
// ---------------------------------------------------------------------------
// tb_lr35902_dma
//
// Self-checking bench for lr35902_dma. Stimulus pushes the expected OAM
// write stream into a scoreboard queue; a monitor on the falling edge pops
// and compares on every wr, and checks strobe/drive invariants each cycle.
// ---------------------------------------------------------------------------
module tb_lr35902_dma;

  localparam int NBYTES = 160;
  localparam int XFER_CLKS = NBYTES * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  reg_din;
  logic        reg_write;
  logic [7:0]  reg_dout;
  logic [15:0] adr_rd;
  logic        rd;
  logic [7:0]  data_in;
  logic [7:0]  adr_wr;
  logic        wr;
  logic [7:0]  data_out;
  logic        active;
  logic        drv_ext;

  logic [7:0]  key;
  logic [7:0]  exp_hi;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  adr_wr;
    logic [7:0]  data;
    logic [15:0] adr_rd;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  lr35902_dma #(
    .BYTES(NBYTES),
    .CLK_PER_BYTE(4),
    .START_DELAY(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .reg_din(reg_din),
    .reg_write(reg_write),
    .reg_dout(reg_dout),
    .adr_rd(adr_rd),
    .rd(rd),
    .data_in(data_in),
    .adr_wr(adr_wr),
    .wr(wr),
    .data_out(data_out),
    .active(active),
    .drv_ext(drv_ext)
  );

  always #5 clk = ~clk;

  // Source memory model: byte at any address = low address byte ^ key.
  assign data_in = adr_rd[7:0] ^ key;

  function automatic logic [7:0] src_of(input logic [7:0] p);
    if (p >= 8'hE0) return p - 8'h20;
    return p;
  endfunction

  function automatic logic exp_drv(input logic [7:0] hi);
    return !(hi >= 8'h80 && hi <= 8'h9F);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: a transfer of page p writes OAM n with source byte {src,n}.
  task automatic push_transfer(input logic [7:0] p);
    exp_q.delete();
    for (int n = 0; n < NBYTES; n++) begin
      exp_q.push_back('{adr_wr: 8'(n), data: 8'(n) ^ key, adr_rd: {src_of(p), 8'(n)}});
    end
  endtask

  task automatic begin_write(input logic [7:0] p);
    reg_din   = p;
    reg_write = 1'b1;
    push_transfer(p);
  endtask

  task automatic end_write(input logic [7:0] p);
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    exp_hi    = src_of(p);
  endtask

  // Called at cycle 0 after the write edge: checks the start delay, the
  // first read, and the length of the active window.
  task automatic delay_phase(input logic [7:0] p, input logic exp_act);
    int  n;
    bit  done;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("delay_rd", rd, 0);
      check("delay_active", active, exp_act);
    end
    @(negedge clk);
    check("first_rd", rd, 1);
    check("first_adr_rd", adr_rd, {src_of(p), 8'h00});
    n = 1;
    done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (active) n++;
      else done = 1;
    end
    check("active_done", done, 1);
    check("active_clks", n, XFER_CLKS);
    check("all_writes_seen", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_fresh(input logic [7:0] p);
    begin_write(p);
    end_write(p);
    check("reg_dout", reg_dout, p);
    delay_phase(p, 1'b0);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (wr) begin
        check("wr_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("adr_wr", adr_wr, mon_e.adr_wr);
          check("data_out", data_out, mon_e.data);
          check("wr_adr_rd", adr_rd, mon_e.adr_rd);
        end
      end
      if (rd) begin
        check("rd_src_hi", adr_rd[15:8], exp_hi);
      end
      if (rd || wr) begin
        check("drv_ext", drv_ext, exp_drv(exp_hi));
      end
      if (!active) begin
        check("idle_strobes", {rd, wr, drv_ext}, 0);
      end
    end
  end

  initial begin
    logic [7:0] p;
    int strobes;

    reset     = 1'b1;
    reg_din   = '0;
    reg_write = 1'b0;
    key       = 8'h00;
    exp_hi    = 8'h00;
    #2;
    check("rst_active", active, 0);
    check("rst_strobes", {rd, wr, drv_ext}, 0);
    check("rst_adr_rd", adr_rd, 16'h0000);
    check("rst_adr_wr", adr_wr, 8'h00);
    check("rst_data_out", data_out, 8'h00);
    check("rst_reg_dout", reg_dout, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Work RAM page, external bus
    key = 8'($urandom);
    run_fresh(8'hC1);

    // VRAM page, no external drive
    key = 8'h5A;
    run_fresh(8'h80);

    // Echo page
    key = 8'($urandom);
    run_fresh(8'hFE);

    // Restart at byte 50 phase 1 (cycle 4 + 4*50 + 1)
    key = 8'($urandom);
    begin_write(8'hC0);
    end_write(8'hC0);
    repeat (205) @(posedge clk);
    #1;
    check("restart_mid_rd", rd, 1);
    begin_write(8'hD0);
    end_write(8'hD0);
    check("restart_reg_dout", reg_dout, 8'hD0);
    delay_phase(8'hD0, 1'b1);

    // Restart coinciding with the final write phase (cycle 4 + 4*159 + 3)
    key = 8'($urandom);
    begin_write(8'h12);
    end_write(8'h12);
    repeat (643) @(posedge clk);
    #1;
    check("final_wr_phase", wr, 1);
    check("final_wr_idx", adr_wr, 8'h9F);
    begin_write(8'hE5);
    #1;
    check("final_wr_masked", wr, 0);
    check("final_active", active, 1);
    end_write(8'hE5);
    delay_phase(8'hE5, 1'b1);

    // Asynchronous reset during byte 10 phase 3 (cycle 47)
    key = 8'($urandom);
    begin_write(8'hC3);
    end_write(8'hC3);
    repeat (47) @(posedge clk);
    #1;
    check("pre_reset_wr", wr, 1);
    #1;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_strobes", {rd, wr, drv_ext, active}, 0);
    check("async_rst_adr_rd", adr_rd, 16'h0000);
    check("async_rst_adr_wr", adr_wr, 8'h00);
    check("async_rst_data", data_out, 8'h00);
    check("async_rst_reg_dout", reg_dout, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    strobes = 0;
    repeat (60) begin
      @(negedge clk);
      if (rd || wr || active) strobes++;
    end
    check("post_reset_quiet", strobes, 0);
    @(posedge clk);
    #1;

    // Random pages
    for (int t = 0; t < 3; t++) begin
      key = 8'($urandom);
      p = 8'($urandom_range(0, 255));
      run_fresh(p);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
